// File: rtl/ram_io_responder_pkg.sv
// Shared constants and helpers for the CPU byte-bus target (RAM + IO window).
package ram_io_responder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 32;

    localparam logic [17:0] IO_BASE     = 18'h30000;
    localparam logic [2:0]  IO_PORT_OFS = 3'd0;
    localparam logic [2:0]  IO_CLK_OFS  = 3'd4;

    typedef enum logic {
        SelRam = 1'b0,
        SelIo  = 1'b1
    } rd_sel_e;

    function automatic logic is_io_addr(input logic [1:0] region);
        return region == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Circular byte FIFO with combinational head read; also exports the next-state
// count so the owner can register a look-ahead near-full flag.
module ram_io_responder_byte_fifo #(
    parameter int unsigned DepthLog2 = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [7:0]           data_i,
    input  logic                 pop_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic [DepthLog2:0]   count_next_o
);

    localparam int unsigned Depth = 1 << DepthLog2;
    localparam int unsigned CntW  = DepthLog2 + 1;

    logic [7:0]           mem_q [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 do_push, do_pop;

    assign valid_o      = (count_q != '0);
    assign full_o       = (count_q == CntW'(Depth));
    assign do_push      = push_i && !full_o;
    assign do_pop       = pop_i && valid_o;
    // Empty FIFO presents 0 so stale storage never leaks onto the head.
    assign data_o       = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_next_o = count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DepthLog2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DepthLog2'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Target side of the CPU byte bus: mirrored byte RAM with 1-cycle read latency
// plus an IO window (UART tx FIFO, rx pop, cycle counter, program-stop flag).
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W    = 17,
    parameter int unsigned TX_DEPTH_LOG2 = 3,
    parameter int unsigned FULL_MARGIN   = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic [BYTE_W-1:0] mem_dout,
    input  logic              mem_wr,
    output logic [BYTE_W-1:0] mem_din,
    output logic              io_buffer_full,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_pop,
    output logic              program_done,
    output logic              tx_overflow
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_W;
    localparam int unsigned TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam int unsigned CNT_W     = TX_DEPTH_LOG2 + 1;

    logic                  is_io;
    logic [2:0]            io_ofs;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  unused_addr_hi;

    assign is_io          = is_io_addr(mem_a[17:16]);
    assign io_ofs         = mem_a[2:0];
    assign ram_idx        = mem_a[RAM_ADDR_W-1:0];
    assign unused_addr_hi = ^mem_a[ADDR_W-1:18];

    // Byte RAM: contents deliberately survive reset.
    logic [BYTE_W-1:0] ram [RAM_DEPTH];

    always_ff @(posedge clk_in) begin
        if (mem_wr && !is_io) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // IO read mux and side effects, evaluated for the address presented this cycle.
    logic [BYTE_W-1:0] io_rd_d, io_rd_q, ram_rd_q;
    logic [23:0]       snap_d, snap_q;
    logic [31:0]       cnt_q;
    logic              rx_pop_d, rx_pop_q;
    rd_sel_e           sel_q;

    always_comb begin
        io_rd_d  = '0;
        snap_d   = snap_q;
        rx_pop_d = 1'b0;
        if (is_io && !mem_wr) begin
            case (io_ofs)
                IO_PORT_OFS: begin
                    if (rx_valid) begin
                        io_rd_d  = rx_data;
                        rx_pop_d = 1'b1;
                    end
                end
                // Byte 0 is returned live; the upper bytes are latched so the
                // following 5..7 reads see the same counter value.
                IO_CLK_OFS: begin
                    io_rd_d = cnt_q[7:0];
                    snap_d  = cnt_q[31:8];
                end
                3'd5:    io_rd_d = snap_q[7:0];
                3'd6:    io_rd_d = snap_q[15:8];
                3'd7:    io_rd_d = snap_q[23:16];
                default: io_rd_d = '0;
            endcase
        end
    end

    assign mem_din = (sel_q == SelIo) ? io_rd_q : ram_rd_q;
    assign rx_pop  = rx_pop_q;

    // TX path
    logic             tx_push_req, tx_fifo_full;
    logic [CNT_W-1:0] tx_count_next, tx_free_next;
    logic             full_q, prog_done_q, tx_ovf_q;

    assign tx_push_req  = mem_wr && is_io && (io_ofs == IO_PORT_OFS) && (mem_dout != '0);
    assign tx_free_next = CNT_W'(TX_DEPTH) - tx_count_next;

    ram_io_responder_byte_fifo #(
        .DepthLog2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_i        (clk_in),
        .rst_ni       (rst_in),
        .push_i       (tx_push_req),
        .data_i       (mem_dout),
        .pop_i        (tx_ready),
        .data_o       (tx_data),
        .valid_o      (tx_valid),
        .full_o       (tx_fifo_full),
        .count_next_o (tx_count_next)
    );

    assign io_buffer_full = full_q;
    assign program_done   = prog_done_q;
    assign tx_overflow    = tx_ovf_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ram_rd_q    <= '0;
            io_rd_q     <= '0;
            sel_q       <= SelRam;
            snap_q      <= '0;
            cnt_q       <= '0;
            rx_pop_q    <= 1'b0;
            full_q      <= 1'b0;
            prog_done_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            ram_rd_q <= ram[ram_idx];
            io_rd_q  <= io_rd_d;
            sel_q    <= (is_io && !mem_wr) ? SelIo : SelRam;
            snap_q   <= snap_d;
            cnt_q    <= cnt_q + 32'd1;
            rx_pop_q <= rx_pop_d;
            // Look-ahead margin hides the CPU's one-cycle reaction lag.
            full_q   <= (tx_free_next <= CNT_W'(FULL_MARGIN));
            if (mem_wr && is_io && (io_ofs == IO_CLK_OFS)) begin
                prog_done_q <= 1'b1;
            end
            if (tx_push_req && tx_fifo_full) begin
                tx_ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: read expectations are queued when the
// address is driven and checked one cycle later; tx bytes are queued on push.
module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_pop;
    logic        program_done;
    logic        tx_overflow;

    ram_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pop         (rx_pop),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned due;
        logic [7:0]  exp;
        string       tag;
    } sb_t;

    sb_t         sb[$];
    logic [7:0]  tx_exp[$];
    int unsigned cyc = 0;
    int unsigned run_edges = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Edges seen since reset release == value the counter holds before the next edge.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) run_edges <= 0;
        else         run_edges <= run_edges + 1;
    end

    always @(negedge clk_in) begin
        sb_t e;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) check_eq({e.tag, "_timing"}, cyc, e.due);
            check_eq(e.tag, {24'd0, mem_din}, {24'd0, e.exp});
        end
    end

    // One bus cycle starting now (caller is at a negedge); returns #1 after the edge.
    task automatic drive_op(input logic wr, input logic [31:0] addr, input logic [7:0] data,
                            input logic chk, input logic [7:0] exp, input string tag);
        sb_t e;
        mem_wr   = wr;
        mem_a    = addr;
        mem_dout = data;
        if (chk) begin
            e.due = cyc + 1;
            e.exp = exp;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk_in);
        #1;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk_in);
        drive_op(1'b1, addr, data, 1'b0, 8'h00, "");
    endtask

    task automatic bus_rd(input logic [31:0] addr, input logic [7:0] exp, input string tag);
        @(negedge clk_in);
        drive_op(1'b0, addr, 8'h00, 1'b1, exp, tag);
    endtask

    logic [31:0] rnd_addr [12];
    logic [7:0]  rnd_data [12];
    int          drained;

    initial begin
        #3;
        check_eq("rst_mem_din", {24'd0, mem_din}, 32'h0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check_eq("rst_full", {31'd0, io_buffer_full}, 32'h0);
        check_eq("rst_rx_pop", {31'd0, rx_pop}, 32'h0);
        check_eq("rst_done", {31'd0, program_done}, 32'h0);
        check_eq("rst_ovf", {31'd0, tx_overflow}, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // RAM: write then immediate read, pipelined reads, mirror alias
        bus_wr(32'h0_0010, 8'hA5);
        bus_rd(32'h0_0010, 8'hA5, "ram_wr_rd");
        bus_wr(32'h0_0011, 8'h3C);
        bus_rd(32'h0_0010, 8'hA5, "ram_b2b0");
        bus_rd(32'h0_0011, 8'h3C, "ram_b2b1");
        bus_rd(32'h2_0010, 8'hA5, "ram_mirror");
        for (int i = 0; i < 12; i++) begin
            rnd_addr[i] = 32'h1000 + i * 32'h123;
            rnd_data[i] = 8'($urandom_range(0, 255));
            bus_wr(rnd_addr[i], rnd_data[i]);
        end
        for (int i = 0; i < 12; i++) bus_rd(rnd_addr[i], rnd_data[i], "ram_rand");

        // TX fill with no drain: near-full after 6, overflow on the 9th
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_wr(32'h3_0000, 8'h41 + 8'(i));
            if (i < 8) tx_exp.push_back(8'h41 + 8'(i));
            check_eq("tx_full_flag", {31'd0, io_buffer_full}, (i >= 5) ? 32'd1 : 32'd0);
            if (i == 7) check_eq("tx_ovf_at8", {31'd0, tx_overflow}, 32'd0);
        end
        check_eq("tx_ovf_at9", {31'd0, tx_overflow}, 32'd1);
        check_eq("tx_head", {24'd0, tx_data}, 32'h41);
        @(negedge clk_in);
        tx_ready = 1'b1;
        drained = 0;
        for (int k = 0; k < 20; k++) begin
            if (!tx_valid) break;
            if (tx_exp.size() == 0) check_eq("tx_extra", {31'd0, tx_valid}, 32'd0);
            else check_eq("tx_drain", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
            drained++;
            @(negedge clk_in);
        end
        check_eq("tx_drained_cnt", drained, 32'd8);
        check_eq("tx_exp_left", tx_exp.size(), 32'd0);
        check_eq("tx_full_clear", {31'd0, io_buffer_full}, 32'd0);

        // Push into empty with drain enabled, then simultaneous push/pop
        bus_wr(32'h3_0000, 8'h61);
        check_eq("tx_push_empty_v", {31'd0, tx_valid}, 32'd1);
        check_eq("tx_push_empty_d", {24'd0, tx_data}, 32'h61);
        bus_wr(32'h3_0000, 8'h62);
        check_eq("tx_pushpop_v", {31'd0, tx_valid}, 32'd1);
        check_eq("tx_pushpop_d", {24'd0, tx_data}, 32'h62);
        @(posedge clk_in);
        #1;
        check_eq("tx_pushpop_end", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Ignored writes and program stop
        bus_wr(32'h3_0000, 8'h00);
        check_eq("tx_null_write", {31'd0, tx_valid}, 32'd0);
        bus_wr(32'h3_0001, 8'h33);
        check_eq("tx_other_ofs", {31'd0, tx_valid}, 32'd0);
        check_eq("done_before", {31'd0, program_done}, 32'd0);
        bus_wr(32'h3_0004, 8'h01);
        check_eq("done_set", {31'd0, program_done}, 32'd1);
        repeat (5) @(posedge clk_in);
        #1;
        check_eq("done_sticky", {31'd0, program_done}, 32'd1);

        // Counter: snapshot at 0x4FF so a live byte-1 read would tear to 0x05
        @(negedge clk_in);
        for (int i = 0; i < 4000 && run_edges != 32'h4FF; i++) @(negedge clk_in);
        check_eq("cnt_wait", run_edges, 32'h4FF);
        drive_op(1'b0, 32'h3_0004, 8'h00, 1'b1, 8'hFF, "cnt_b0");
        bus_rd(32'h3_0005, 8'h04, "cnt_b1");
        bus_rd(32'h3_0006, 8'h00, "cnt_b2");
        bus_rd(32'h3_0007, 8'h00, "cnt_b3");

        // RX pop
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        bus_rd(32'h3_0000, 8'h7E, "rx_data");
        check_eq("rx_pop_pulse", {31'd0, rx_pop}, 32'd1);
        @(posedge clk_in);
        #1;
        check_eq("rx_pop_end", {31'd0, rx_pop}, 32'd0);
        rx_valid = 1'b0;
        bus_rd(32'h3_0000, 8'h00, "rx_empty");
        check_eq("rx_no_pop", {31'd0, rx_pop}, 32'd0);
        bus_rd(32'h3_0002, 8'h00, "io_other_ofs");

        // Async reset mid-read with 3 bytes queued
        bus_wr(32'h3_0000, 8'h71);
        bus_wr(32'h3_0000, 8'h72);
        bus_wr(32'h3_0000, 8'h73);
        check_eq("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
        @(negedge clk_in);
        mem_a = 32'h0_0010;
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("mid_rst_mem_din", {24'd0, mem_din}, 32'h0);
        check_eq("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("mid_rst_tx_data", {24'd0, tx_data}, 32'h0);
        check_eq("mid_rst_done", {31'd0, program_done}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, tx_overflow}, 32'd0);
        mem_a = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        drive_op(1'b0, 32'h3_0004, 8'h00, 1'b1, 8'h00, "cnt_restart");
        bus_rd(32'h0_0010, 8'hA5, "ram_kept0");
        bus_rd(32'h0_0011, 8'h3C, "ram_kept1");
        check_eq("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);

        @(negedge clk_in);
        @(negedge clk_in);
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Target-side model of the CPU byte bus (`mem_a`, `mem_dout`, `mem_wr` in; `mem_din` out).
- Serves a byte RAM with 1-cycle read latency and zero-wait writes.
- Decodes the IO window (`mem_a[17:16]==2'b11`):
  - UART tx FIFO with `io_buffer_full` back-pressure.
  - UART rx byte pop.
  - Free-running cycle counter.
  - Program-stop flag.
- Sits below the CPU top in the FPGA/sim wrapper; replaces the ad-hoc ram + hci pair.

Parameters:
- `RAM_ADDR_W`, 17: byte RAM depth = `2**RAM_ADDR_W` (128 KB).
- `TX_DEPTH_LOG2`, 3: tx FIFO depth = 8 entries.
- `FULL_MARGIN`, 2: assert full when free slots <= `FULL_MARGIN`.

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  asynchronous, active-low reset
- `mem_a`  in  32  CPU address (bits 17:0 decoded)
- `mem_dout`  in  8  CPU write data
- `mem_wr`  in  1  1 = write, 0 = read
- `mem_din`  out  8  read data to CPU, valid the cycle after the address
- `io_buffer_full`  out  1  tx FIFO near-full
- `tx_valid`  out  1  tx FIFO head valid
- `tx_data`  out  8  tx FIFO head byte
- `tx_ready`  in  1  UART accepted head this cycle
- `rx_valid`  in  1  UART rx byte available
- `rx_data`  in  8  UART rx byte
- `rx_pop`  out  1  one-cycle pulse: rx byte consumed
- `program_done`  out  1  sticky, set by stop write
- `tx_overflow`  out  1  sticky, a write hit a truly full FIFO

Behaviour:

Reset (`rst_in` low, async):
- `mem_din`=0, `tx_valid`=0, `tx_data`=0, `io_buffer_full`=0, `rx_pop`=0, `program_done`=0, `tx_overflow`=0.
- FIFO pointers and count = 0; cycle counter = 0; read-select register = RAM.
- RAM contents are NOT cleared.

Decode:
- `is_io = (mem_a[17:16]==2'b11)`.
- RAM index = `mem_a[RAM_ADDR_W-1:0]`; RAM is mirrored, with no bounds fault.

RAM write (`mem_wr=1`, `!is_io`):
- Byte stored at the rising edge.
- A read of the same address in the next cycle returns the new byte.

RAM read (`mem_wr=0`, `!is_io`):
- Array read registered at edge N; `mem_din` valid for the whole of cycle N+1.
- Back-to-back reads are pipelined: one byte per cycle.

IO read, registered the same way, by `mem_a[2:0]`:
- 0 (0x30000):
  - `rx_valid=1`: `mem_din=rx_data`; `rx_pop` pulses in cycle N+1.
  - `rx_valid=0`: `mem_din=0x00`; no pop.
- 4 (0x30004): snapshot the counter into a 32-bit latch; return byte 0.
- 5..7: return snapshot bytes 1..3 (little-endian). They read the latch, never the live counter, so a 4-byte read sequence is coherent.
- Other offsets return 0x00.

IO write:
- Offset 0:
  - `mem_dout==0x00` is ignored.
  - Otherwise push to the tx FIFO.
  - If the FIFO is truly full (count == depth): byte dropped, `tx_overflow` set.
- Offset 4: `program_done` <= 1.
- Other offsets ignored.

Cycle counter:
- 32-bit; +1 every cycle after reset release; wraps `0xFFFFFFFF` -> 0.

TX FIFO:
- Circular buffer with a count of width `TX_DEPTH_LOG2+1`.
- `tx_valid = (count!=0)`; `tx_data` = head entry (registered storage, combinational head read).
- Pop when `tx_valid && tx_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO appears on `tx_valid` the next cycle.

`io_buffer_full`:
- Registered from the next-state count: `(DEPTH - count_next) <= FULL_MARGIN`.
- Covers the CPU's one-cycle reaction lag.

Reset mid-operation:
- Any in-flight read is discarded; `mem_din` returns to 0 and FIFO contents are lost.

Decomposition:
- Shared package (`defines`):
  - `IO_BASE` 0x30000, `IO_PORT_OFS` 0, `IO_CLK_OFS` 4.
  - Byte and address width macros.
- Sub-module `byte_fifo`: parameterised depth, push/pop/count, async active-low reset; instantiated for tx.
- Top contains decode, RAM array, read mux register, counter, snapshot latch and flags.

Test Plan:
1. Write 0xA5 to 0x00010, read 0x00010 next cycle -> `mem_din`=0xA5 exactly one cycle after the read address; reads of 0x10, 0x11 in consecutive cycles return bytes in order.
2. With `tx_ready`=0, write 0x41 six times to 0x30000 -> `io_buffer_full` rises after the 6th push (free = 2); two more writes -> count 8, `tx_overflow`=0; a 9th write -> `tx_overflow`=1 and count stays 8.
3. Write 0x00 to 0x30000 -> FIFO count unchanged, `tx_valid` stays 0; write 0x30004 -> `program_done`=1 and stays set.
4. After 1000 cycles from reset, read 0x30004..0x30007 on consecutive cycles -> the bytes assemble the counter value at the 0x30004 read edge (0x000003E8 ± fixed offset); the value does not tear.
5. `rx_valid`=1, `rx_data`=0x7E, read 0x30000 -> `mem_din`=0x7E and one `rx_pop` pulse; with `rx_valid`=0 -> `mem_din`=0x00 and no pulse.
6. Assert `rst_in`=0 mid-read with the FIFO holding 3 bytes -> all outputs 0 immediately (async); after release the counter restarts at 0 and previously written RAM bytes are still readable.
